// File: rtl/axi_slave_ram_burst_rd.sv
// AXI4 read-only slave RAM: queued AR bursts (FIXED/INCR/WRAP, narrow sizes),
// SLVERR on unsupported requests, and a backdoor word-write preload port.
module axi_slave_ram_burst_rd #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned AR_FIFO_DEPTH = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [ID_WIDTH-1:0]      arid,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [ID_WIDTH-1:0]      rid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     init_we,
  input  logic [ADDRESS_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0]    init_data
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned LOG2B  = $clog2(BYTES);
  localparam int unsigned WIDX_W = ADDRESS_WIDTH - LOG2B;
  localparam int unsigned WORDS  = 2 ** WIDX_W;
  localparam int unsigned IDX_W  = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned SLOTS  = 2 ** IDX_W;
  localparam int unsigned ENT_W  = ADDRESS_WIDTH + ID_WIDTH + 13;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0]    r_mem [WORDS];
  logic [ENT_W-1:0]         r_fifo [SLOTS];
  logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
  logic                     r_arready;

  logic [ADDRESS_WIDTH-1:0] r_addr, r_wmask;
  logic [2:0]               r_size;
  logic [1:0]               r_burst;
  logic                     r_err;
  logic [7:0]               r_cnt;
  logic [ID_WIDTH-1:0]      r_rid;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [1:0]               r_rresp;
  logic                     r_rlast, r_rvalid;

  logic [PTR_W-1:0]         w_count, w_count_nxt;
  logic                     w_empty, w_push, w_pop, w_adv, w_done;
  logic [ENT_W-1:0]         w_head;
  logic [ADDRESS_WIDTH-1:0] w_h_addr, w_h_wmask;
  logic [ID_WIDTH-1:0]      w_h_id;
  logic [7:0]               w_h_len;
  logic [2:0]               w_h_size;
  logic [1:0]               w_h_burst;
  logic                     w_h_err, w_h_wrap_ok;
  logic [31:0]              w_h_total;
  logic [DATA_WIDTH-1:0]    w_h_data, w_next_data;
  logic [ADDRESS_WIDTH-1:0] w_step, w_aligned, w_inc, w_next_addr;

  // Backdoor preload; contents survive reset.
  always_ff @(posedge aclk) begin
    if (init_we) r_mem[WIDX_W'(init_addr >> LOG2B)] <= init_data;
  end

  // AR queue storage
  always_ff @(posedge aclk) begin
    if (w_push) r_fifo[r_wr_ptr[IDX_W-1:0]] <= {araddr, arid, arlen, arsize, arburst};
  end

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_push      = arvalid && r_arready;
  assign w_count_nxt = w_count + PTR_W'(w_push) - PTR_W'(w_pop);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_arready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_arready <= (w_count_nxt != PTR_W'(AR_FIFO_DEPTH));
    end
  end

  // Decode of the burst at the queue head
  assign w_head = r_fifo[r_rd_ptr[IDX_W-1:0]];
  assign {w_h_addr, w_h_id, w_h_len, w_h_size, w_h_burst} = w_head;

  assign w_h_wrap_ok = (w_h_len == 8'd1) || (w_h_len == 8'd3) ||
                       (w_h_len == 8'd7) || (w_h_len == 8'd15);
  assign w_h_err     = (w_h_size > 3'(LOG2B)) || (w_h_burst == 2'd3) ||
                       ((w_h_burst == 2'd2) && !w_h_wrap_ok);
  assign w_h_total   = (32'(w_h_len) + 32'd1) << w_h_size;
  assign w_h_wmask   = ADDRESS_WIDTH'(w_h_total - 32'd1);
  assign w_h_data    = w_h_err ? '0 : r_mem[WIDX_W'(w_h_addr >> LOG2B)];

  // Next beat address within the active burst
  assign w_step    = ADDRESS_WIDTH'(1) << r_size;
  assign w_aligned = r_addr & ~(w_step - ADDRESS_WIDTH'(1));
  assign w_inc     = w_aligned + w_step;

  always_comb begin
    w_next_addr = w_inc;
    case (r_burst)
      2'd0:    w_next_addr = r_addr;
      2'd2:    w_next_addr = (w_aligned & ~r_wmask) | (w_inc & r_wmask);
      default: w_next_addr = w_inc;
    endcase
  end

  assign w_next_data = r_err ? '0 : r_mem[WIDX_W'(w_next_addr >> LOG2B)];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Engine: a final-beat handshake chains straight into the next queued burst
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (rready) begin
          if (!r_rlast)      w_adv = 1'b1;
          else if (!w_empty) w_pop = 1'b1;
          else begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_addr   <= '0;
      r_wmask  <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
      r_rvalid <= 1'b0;
    end else if (w_pop) begin
      r_addr   <= w_h_addr;
      r_wmask  <= w_h_wmask;
      r_size   <= w_h_size;
      r_burst  <= w_h_burst;
      r_err    <= w_h_err;
      r_cnt    <= w_h_len;
      r_rid    <= w_h_id;
      r_rdata  <= w_h_data;
      r_rresp  <= w_h_err ? 2'b10 : 2'b00;
      r_rlast  <= (w_h_len == 8'd0);
      r_rvalid <= 1'b1;
    end else if (w_adv) begin
      r_addr   <= w_next_addr;
      r_cnt    <= r_cnt - 8'd1;
      r_rdata  <= w_next_data;
      r_rlast  <= (r_cnt == 8'd1);
    end else if (w_done) begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end
  end

  assign arready = r_arready;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
  assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_axi_slave_ram_burst_rd.sv
// Scoreboard bench for axi_slave_ram_burst_rd: expected beats are queued when
// ARs are issued; a negedge monitor checks every presented R beat in order.
module tb_axi_slave_ram_burst_rd;

  logic        aclk, areset;
  logic [7:0]  araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        init_we;
  logic [7:0]  init_addr;
  logic [31:0] init_data;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  logic stall  = 1'b0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t q[$];

  axi_slave_ram_burst_rd dut (
    .aclk(aclk), .areset(areset),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Push n expected beats (words w0..w3) of a burst that is nb beats long
  task automatic exp_beats(input logic [3:0] id, input int n, input int nb, input logic err,
                           input int w0, input int w1, input int w2, input int w3);
    int w[4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.id   = id;
      b.data = err ? 32'h0 : 32'h1000_0000 + 32'(w[i]);
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == nb - 1);
      q.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic ar_issue(input logic [7:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok      = 1'b0;
    araddr  = addr;
    arid    = id;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge aclk);
      if (arready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1 arvalid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ar_timeout id=%0d arready=%0b required=1", id, arready);
    end
  endtask

  task automatic drain();
    rready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (q.size() == 0) break;
      @(posedge aclk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  // Monitor: every presented beat must match the queue head; pop on handshake
  always @(negedge aclk) begin
    if (areset) begin
      stall = 1'b0;
    end else begin
      if (stall) chk("stall_rvalid", 64'(rvalid), 64'd1);
      if (rvalid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat rid=%0d rdata=%h required=no_beat", rid, rdata);
        end else begin
          chk("beat", 64'({rid, rdata, rresp, rlast}),
              64'({q[0].id, q[0].data, q[0].resp, q[0].last}));
          if (rready) begin
            void'(q.pop_front());
            beats++;
          end
        end
      end
      stall = rvalid && !rready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int b0;
    areset = 1'b1; arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0;
    arsize = '0; arburst = '0; rready = 1'b0;
    init_we = 1'b0; init_addr = '0; init_data = '0;

    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", 64'({arready, rvalid, rlast, rid, rdata, rresp}), 64'd0);
    areset = 1'b0;
    @(posedge aclk);
    #1 chk("arready_after_reset", 64'(arready), 64'd1);

    for (int i = 0; i < 16; i++) begin
      init_we   = 1'b1;
      init_addr = 8'(i * 4);
      init_data = 32'h1000_0000 + 32'(i);
      @(posedge aclk);
      #1;
    end
    init_we = 1'b0;

    // INCR 0x08 len3 size2, plus two-edge latency
    rready = 1'b1;
    exp_beats(4'd5, 4, 4, 1'b0, 2, 3, 4, 5);
    ar_issue(8'h08, 4'd5, 8'd3, 3'd2, 2'd1);
    chk("latency_edge1", 64'(rvalid), 64'd0);
    @(posedge aclk);
    #1 chk("latency_edge2", 64'(rvalid), 64'd1);
    drain();

    // WRAP 0x18 len3 size2 and narrow INCR 0x01 size0
    exp_beats(4'd6, 4, 4, 1'b0, 6, 7, 4, 5);
    ar_issue(8'h18, 4'd6, 8'd3, 3'd2, 2'd2);
    drain();
    exp_beats(4'd7, 3, 3, 1'b0, 0, 0, 0, 0);
    ar_issue(8'h01, 4'd7, 8'd2, 3'd0, 2'd1);
    drain();

    // FIXED with rready stalls
    rready = 1'b0;
    exp_beats(4'd8, 3, 3, 1'b0, 3, 3, 3, 0);
    ar_issue(8'h0C, 4'd8, 8'd2, 3'd2, 2'd0);
    for (int t = 0; t < 40; t++) begin
      if (q.size() == 0) break;
      rready = ((t % 3) == 0);
      @(posedge aclk);
      #1;
    end
    drain();

    // AR queue backpressure and back-to-back bursts
    rready = 1'b0;
    exp_beats(4'd1, 2, 2, 1'b0, 0, 1, 0, 0);
    ar_issue(8'h00, 4'd1, 8'd1, 3'd2, 2'd1);
    exp_beats(4'd2, 2, 2, 1'b0, 8, 9, 0, 0);
    ar_issue(8'h20, 4'd2, 8'd1, 3'd2, 2'd1);
    exp_beats(4'd3, 2, 2, 1'b0, 12, 13, 0, 0);
    ar_issue(8'h30, 4'd3, 8'd1, 3'd2, 2'd1);
    repeat (3) begin
      @(negedge aclk);
      chk("arready_full", 64'(arready), 64'd0);
    end
    @(posedge aclk);
    #1;
    exp_beats(4'd4, 2, 2, 1'b0, 14, 15, 0, 0);
    fork
      ar_issue(8'h38, 4'd4, 8'd1, 3'd2, 2'd1);
      begin
        b0 = beats;
        rready = 1'b1;
        repeat (6) @(posedge aclk);
        #1 chk("no_bubble_beats", 64'(beats - b0), 64'd6);
      end
    join
    drain();

    // SLVERR: oversize, reserved burst, illegal WRAP length
    exp_beats(4'd9, 2, 2, 1'b1, 0, 0, 0, 0);
    ar_issue(8'h00, 4'd9, 8'd1, 3'd3, 2'd1);
    exp_beats(4'd10, 2, 2, 1'b1, 0, 0, 0, 0);
    ar_issue(8'h00, 4'd10, 8'd1, 3'd2, 2'd3);
    exp_beats(4'd11, 3, 3, 1'b1, 0, 0, 0, 0);
    ar_issue(8'h00, 4'd11, 8'd2, 3'd2, 2'd2);
    drain();

    // Reset in the middle of a len-7 burst
    exp_beats(4'd12, 2, 8, 1'b0, 0, 1, 0, 0);
    ar_issue(8'h00, 4'd12, 8'd7, 3'd2, 2'd1);
    for (int t = 0; t < 20; t++) begin
      if (q.size() == 0) break;
      @(posedge aclk);
      #1;
    end
    chk("pre_reset_beats_done", 64'(q.size()), 64'd0);
    areset = 1'b1;
    #1 chk("reset_mid_burst", 64'({rvalid, rlast, rresp, rdata, arready}), 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk);
    #1 chk("arready_after_release", 64'(arready), 64'd1);
    exp_beats(4'd13, 2, 2, 1'b0, 4, 5, 0, 0);
    ar_issue(8'h10, 4'd13, 8'd1, 3'd2, 2'd1);
    drain();

    // Backdoor rewrite of word 9 is seen by a later fetch
    init_we   = 1'b1;
    init_addr = 8'h24;
    init_data = 32'h1000_0109;
    @(posedge aclk);
    #1 init_we = 1'b0;
    exp_beats(4'd14, 1, 1, 1'b0, 32'h109, 0, 0, 0);
    ar_issue(8'h24, 4'd14, 8'd0, 3'd2, 2'd1);
    drain();

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    chk("idle_rvalid", 64'(rvalid), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_slave_ram_burst_rd.md
Name: axi_slave_ram_burst_rd

Overview:
Parametrised AXI4 read-only slave RAM, the next generation of axi_slave_ram. It generalises data, address and ID widths and supports FIXED, INCR and WRAP bursts with narrow sizes and SLVERR reporting. An AR queue lets several read bursts be outstanding, and a backdoor port preloads memory contents. It sits behind the interconnect as a read-side memory target.

Parameters:
ADDRESS_WIDTH, 8, byte-address width; memory holds 2^ADDRESS_WIDTH bytes.
DATA_WIDTH, 32, R data width; power of two, 8..128; BYTES = DATA_WIDTH/8.
ID_WIDTH, 4, width of arid/rid.
AR_FIFO_DEPTH, 2, AR queue entries; power of two, at least 1.

Ports:
aclk  in  1  clock; all logic on posedge.
areset  in  1  asynchronous, active-high reset.
araddr  in  ADDRESS_WIDTH  burst start byte address.
arid  in  ID_WIDTH  transaction ID.
arlen  in  8  beats minus 1.
arsize  in  3  log2 bytes per beat.
arburst  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved.
arvalid  in  1  AR valid.
arready  out  1  AR ready.
rid  out  ID_WIDTH  ID of the current burst.
rdata  out  DATA_WIDTH  full memory word containing the beat address.
rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
rlast  out  1  final beat of the burst.
rvalid  out  1  R valid.
rready  in  1  R ready.
init_we  in  1  backdoor word write enable.
init_addr  in  ADDRESS_WIDTH  backdoor byte address; low log2(BYTES) bits ignored.
init_data  in  DATA_WIDTH  backdoor write data.

Behaviour:
- Reset, asynchronous: while areset=1, arready, rvalid, rlast, rid, rdata and rresp are 0. The AR FIFO is emptied and the engine goes to IDLE. Memory contents are not reset.
- Reset mid-burst: rvalid drops immediately and the rest of the burst is discarded. arready=1 on the first cycle after release.
- AR accept: an AR is accepted when arvalid && arready and is pushed to the FIFO. arready = !fifo_full and is decided from registered state only; a pop in the same cycle does not raise it.
- Engine IDLE: if the FIFO is non-empty, pop the head, register the burst context, fetch beat 0 into rdata, set rvalid=1 and go to BURST. Minimum latency is 2 edges from AR handshake to rvalid high.
- Engine BURST: rvalid=1. rid, rdata, rresp and rlast are held stable while !rready.
  - On a handshake at a non-final beat: advance the address, fetch the next word, decrement the count.
  - On the final beat (rlast=1), if the FIFO is non-empty: pop and fetch the next burst's beat 0 on the same edge. rvalid stays 1, with no bubble.
  - On the final beat, if the FIFO is empty: rvalid=0, go to IDLE.
- Beat address: word index = addr >> log2(BYTES). All address arithmetic is modulo 2^ADDRESS_WIDTH.
  - FIXED: address is constant for every beat.
  - INCR: next = align(addr, 2^size) + 2^size.
  - WRAP: total = (arlen+1) << size. next = align(addr, 2^size) + 2^size. When next crosses the total-aligned boundary, next -= total.
- Error: SLVERR when arsize > log2(BYTES), or arburst=3, or WRAP with arlen not in {1,3,7,15}. Error bursts still return arlen+1 beats with rresp=2'b10 and rdata=0, rlast on the final beat, and no memory read.
- Otherwise rresp=2'b00.
- Backdoor write: when init_we=1, mem[init_addr>>log2(BYTES)] <= init_data on the edge. An already-registered rdata is unchanged; later fetches see the new value.
- Bursts complete strictly in acceptance order. There is no reordering by ID.

Test Plan:
- Preload word i = 32'h1000_0000+i for i=0..15. AR INCR addr 0x08, len 3, size 2, id 5 -> 4 beats: words 2,3,4,5, rid=5, rresp=0, rlast on beat 4 only, rvalid 2 edges after handshake.
- AR WRAP addr 0x18, len 3, size 2 -> words 6,7,4,5. AR INCR addr 0x01, len 2, size 0 -> words 0,0,0.
- AR FIXED addr 0x0C, len 2, rready toggling 1,0,0,1,... -> word 3 three times; all outputs stable during stalls.
- AR_FIFO_DEPTH=2, rready=0, four ARs with ids 1..4 -> three accepted, then arready=0. Raise rready -> bursts in order 1,2,3 with no idle cycle between them. The fourth AR is accepted once a slot frees.
- Error bursts, DATA_WIDTH=32: arsize=3 len 1 / arburst=3 len 1 / WRAP len 2 -> 2, 2 and 3 beats respectively, each beat rresp=2'b10, rdata=0, rlast on the last beat.
- Assert areset after beat 1 of a len-7 burst -> rvalid=0 immediately and arready=1 after release. A new INCR burst then returns correct data.
